// File: rtl/fifo_master_port_if.sv
// Command/response handshake bundle between a requester and fifo_master_port.
//   cmd_valid/cmd_ready : command offer / queue can accept
//   cmd_op              : 0 = write, 1 = read
//   cmd_data            : write data (ignored for reads)
//   cmd_bank            : read bank id (ignored for writes)
//   rsp_valid/rsp_ready : read response pending / requester accepts
//   rsp_data            : read data (0 on error)
//   rsp_bank            : bank the read targeted
//   rsp_err             : all read attempts failed
// master = requester side, slave = adapter side.
`timescale 1ns/1ps
interface fifo_master_port_if;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned BANK_W = 2;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic [BANK_W-1:0] cmd_bank;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [BANK_W-1:0] rsp_bank;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_bank, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_bank, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_bank, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_bank, rsp_err
  );
endinterface

// File: rtl/fifo_master_port.sv
// Single-master command adapter in front of one master port of the four-bank
// FIFO. Buffers write/read commands in a small circular queue, turns each one
// into the one-cycle wr_en / rd_en + rd_id pulse protocol, retries reads that
// get no data and reports an error after MAX_ATTEMPTS tries.
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-low reset
//   bus (slave)       : command and response handshakes
//   fifo_wr_en        : write pulse to the bank FIFO
//   fifo_data_in      : write data, 0 outside a write pulse
//   fifo_rd_en        : read pulse to the bank FIFO
//   fifo_rd_id        : read bank id, 0 outside a read pulse
//   fifo_data_out     : read data from the bank FIFO
//   fifo_valid        : read data valid from the bank FIFO
//   wr_cnt            : writes issued, wraps at 256
//   err_cnt           : read errors, saturates at 255
`timescale 1ns/1ps
module fifo_master_port #(
  parameter int unsigned CMD_DEPTH    = 4,
  parameter int unsigned MAX_ATTEMPTS = 4
) (
  input  logic                clk,
  input  logic                rst,
  fifo_master_port_if.slave   bus,
  output logic                fifo_wr_en,
  output logic [7:0]          fifo_data_in,
  output logic                fifo_rd_en,
  output logic [1:0]          fifo_rd_id,
  input  logic [7:0]          fifo_data_out,
  input  logic                fifo_valid,
  output logic [7:0]          wr_cnt,
  output logic [7:0]          err_cnt
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned BANK_W = 2;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned AW     = $clog2(CMD_DEPTH);
  localparam int unsigned QCNT_W = AW + 1;
  localparam int unsigned ATT_W  = 4;

  typedef struct packed {
    logic              op;
    logic [DATA_W-1:0] data;
    logic [BANK_W-1:0] bank;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_WR = 3'd1,
    ISSUE_RD = 3'd2,
    WAIT_RD  = 3'd3,
    RESP     = 3'd4
  } state_t;

  // Command queue storage and pointers
  cmd_t              mem [CMD_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [QCNT_W-1:0] q_count;
  logic              q_full;
  logic              q_empty;
  logic              push;
  logic              pop;
  cmd_t              push_entry;

  // FSM and hold registers
  state_t            state_q, state_d;
  cmd_t              hold_q, hold_d;
  logic [ATT_W-1:0]  att_q, att_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rerr_q, rerr_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  // Full/empty come from the registered count, so a pop never re-opens the
  // queue in the same cycle.
  assign q_full     = (q_count == QCNT_W'(CMD_DEPTH));
  assign q_empty    = (q_count == '0);
  assign push       = bus.cmd_valid & ~q_full;
  assign pop        = (state_q == IDLE) & ~q_empty;
  assign push_entry = '{op: bus.cmd_op, data: bus.cmd_data, bank: bus.cmd_bank};

  // Queue storage: data only, no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally at CMD_DEPTH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      q_count <= q_count + QCNT_W'(push) - QCNT_W'(pop);
    end
  end

  // State and hold registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      att_q     <= '0;
      rdata_q   <= '0;
      rerr_q    <= 1'b0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      att_q     <= att_d;
      rdata_q   <= rdata_d;
      rerr_q    <= rerr_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Next-state and register updates
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    att_d     = att_q;
    rdata_d   = rdata_q;
    rerr_d    = rerr_q;
    wr_cnt_d  = wr_cnt_q;
    err_cnt_d = err_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (!q_empty) begin
          hold_d  = mem[rd_ptr];
          att_d   = '0;
          state_d = mem[rd_ptr].op ? ISSUE_RD : ISSUE_WR;
        end
      end

      ISSUE_WR: begin
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
        state_d  = IDLE;
      end

      ISSUE_RD: begin
        att_d   = att_q + ATT_W'(1);
        state_d = WAIT_RD;
      end

      // fifo_valid is only looked at here, one cycle after the read pulse
      WAIT_RD: begin
        if (fifo_valid) begin
          rdata_d = fifo_data_out;
          rerr_d  = 1'b0;
          state_d = RESP;
        end else if (att_q == ATT_W'(MAX_ATTEMPTS)) begin
          rdata_d = '0;
          rerr_d  = 1'b1;
          if (err_cnt_q != {CNT_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
          end
          state_d = RESP;
        end else begin
          state_d = ISSUE_RD;
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bank FIFO pulses decode straight from state; payload is zero when idle
  assign fifo_wr_en   = (state_q == ISSUE_WR);
  assign fifo_data_in = fifo_wr_en ? hold_q.data : '0;
  assign fifo_rd_en   = (state_q == ISSUE_RD);
  assign fifo_rd_id   = fifo_rd_en ? hold_q.bank : '0;

  // Response port holds its payload for the whole RESP state
  assign bus.cmd_ready = ~q_full;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = bus.rsp_valid ? rdata_q : '0;
  assign bus.rsp_bank  = bus.rsp_valid ? hold_q.bank : '0;
  assign bus.rsp_err   = bus.rsp_valid & rerr_q;

  assign wr_cnt  = wr_cnt_q;
  assign err_cnt = err_cnt_q;

endmodule
